// File: rtl/ddr_sram_bridge.sv
// Bridges single-cycle DDR-side requests onto a 1-cycle-latency SRAM port, with
// an optional wait delay and 8-word line bursts for instruction fetch.
module ddr_sram_bridge #(
   parameter int unsigned EXTRA_LAT = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          ddr_chip_enable,
   input  logic [18:0]   ddr_index,
   input  logic          ddr_write_enable,
   input  logic          ddr_burst_mode,
   input  logic [63:0]   ddr_opstore_write_mask,
   input  logic [63:0]   ddr_opstore_write_data,
   output logic [63:0]   ddr_opload_read_data,
   output logic [511:0]  ddr_pc_read_inst,
   output logic          ddr_operation_done,
   output logic          ddr_ready,
   output logic          sram_ce,
   output logic          sram_we,
   output logic [18:0]   sram_addr,
   output logic [63:0]   sram_wmask,
   output logic [63:0]   sram_wdata,
   input  logic [63:0]   sram_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StAccess,
      StCapture,
      StDone
   } state_e;

   state_e        r_state;
   state_e        w_state_next;

   logic [3:0]    r_cnt;
   logic [2:0]    r_beat;
   logic [18:0]   r_idx;
   logic          r_we;
   logic          r_burst;
   logic [63:0]   r_mask;
   logic [63:0]   r_data;

   logic          r_rd_pend;
   logic          r_rd_burst;
   logic [2:0]    r_rd_beat;
   logic [63:0]   r_opload;
   logic [511:0]  r_inst;

   logic          w_accept;
   logic          w_done;
   logic          w_ce;
   logic          w_we;
   logic [18:0]   w_addr;
   logic [63:0]   w_wmask;
   logic [63:0]   w_wdata;

   assign w_accept = (r_state == StIdle) && ddr_chip_enable;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      ddr_ready    = 1'b0;
      w_done       = 1'b0;
      w_ce         = 1'b0;
      w_we         = 1'b0;
      w_addr       = '0;
      w_wmask      = '0;
      w_wdata      = '0;
      unique case (r_state)
         StIdle: begin
            ddr_ready = 1'b1;
            if (ddr_chip_enable) begin
               w_state_next = (EXTRA_LAT == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            if (r_cnt <= 4'd1) begin
               w_state_next = StAccess;
            end
         end
         StAccess: begin
            w_ce = 1'b1;
            if (r_we) begin
               w_we         = 1'b1;
               w_addr       = r_idx;
               w_wmask      = r_mask;
               w_wdata      = r_data;
               w_state_next = StDone;
            end else if (r_burst) begin
               // Beat counter replaces the low bits, so the burst stays inside the line.
               w_addr = {r_idx[18:3], r_beat};
               if (r_beat == 3'd7) begin
                  w_state_next = StCapture;
               end
            end else begin
               w_addr       = r_idx;
               w_state_next = StCapture;
            end
         end
         StCapture: begin
            w_state_next = StDone;
         end
         StDone: begin
            w_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Reset blocks SRAM traffic and completion within the very cycle it is asserted.
   assign sram_ce            = w_ce & reset_n;
   assign sram_we            = w_we & reset_n;
   assign sram_addr          = reset_n ? w_addr : 19'd0;
   assign sram_wmask         = reset_n ? w_wmask : 64'd0;
   assign sram_wdata         = reset_n ? w_wdata : 64'd0;
   assign ddr_operation_done = w_done & reset_n;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_beat  <= '0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_burst <= 1'b0;
         r_mask  <= '0;
         r_data  <= '0;
      end else if (w_accept) begin
         r_cnt   <= 4'(EXTRA_LAT);
         r_beat  <= '0;
         r_idx   <= ddr_index;
         r_we    <= ddr_write_enable;
         r_burst <= ddr_burst_mode;
         r_mask  <= ddr_opstore_write_mask;
         r_data  <= ddr_opstore_write_data;
      end else begin
         if (r_state == StWait) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if ((r_state == StAccess) && r_burst && !r_we) begin
            r_beat <= r_beat + 3'd1;
         end
      end
   end

   // Read data returns one cycle after issue; remember where it belongs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rd_pend  <= 1'b0;
         r_rd_burst <= 1'b0;
         r_rd_beat  <= '0;
         r_opload   <= '0;
         r_inst     <= '0;
      end else begin
         r_rd_pend  <= w_ce & ~w_we;
         r_rd_burst <= r_burst;
         r_rd_beat  <= r_beat;
         if (r_rd_pend) begin
            if (r_rd_burst) begin
               r_inst[{r_rd_beat, 6'd0} +: 64] <= sram_rdata;
            end else begin
               r_opload <= sram_rdata;
            end
         end
      end
   end

   assign ddr_opload_read_data = r_opload;
   assign ddr_pc_read_inst     = r_inst;

endmodule
